// File: rtl/barrett_pkg.sv
// Shared constants, the Barrett constant helper and the pipeline stage record
// used by the modular-reduction datapath.
package barrett_pkg;

  localparam int WIDTH = 8;
  localparam int K     = WIDTH;
  localparam int Q     = 251;
  localparam int TAG_W = 4;

  // floor(2^(2k) / q); fits in k+1 bits whenever 2^(k-1) < q < 2^k.
  function automatic int unsigned mu_calc(input int unsigned q, input int unsigned k);
    logic [63:0] num;
    num = 64'd1 << (2 * k);
    return 32'(num / 64'(q));
  endfunction

  localparam int MU = int'(mu_calc(Q, K));

  typedef struct packed {
    logic                 valid;
    logic [2*WIDTH-1:0]   data;
    logic [TAG_W-1:0]     tag;
  } stage_t;

endpackage

// File: rtl/barrett_corr.sv
// Final Barrett correction: removes up to two multiples of Q from a partial
// remainder known to be below 3Q.
module barrett_corr #(
  parameter int WIDTH = 8,
  parameter int Q     = 251
) (
  input  logic [WIDTH+1:0] r_i,
  output logic [WIDTH-1:0] res_o
);

  logic [WIDTH+1:0] q_ext;
  logic [WIDTH+1:0] r1;
  logic [WIDTH+1:0] r2;
  logic             unused_hi;

  assign q_ext = (WIDTH+2)'(Q);

  always_comb begin
    r1 = (r_i >= q_ext) ? (r_i - q_ext) : r_i;
    r2 = (r1 >= q_ext) ? (r1 - q_ext) : r1;
  end

  // r2 < Q < 2^WIDTH, so the two top bits are always zero.
  assign res_o     = r2[WIDTH-1:0];
  assign unused_hi = ^r2[WIDTH+1:WIDTH];

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage valid/ready Barrett reduction of a 2*WIDTH-bit product modulo Q,
// with an opaque tag carried alongside each operand.
module barrett_reduce_pipe #(
  parameter int WIDTH = 8,
  parameter int Q     = 251,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  import barrett_pkg::mu_calc;

  localparam int K  = WIDTH;
  localparam int PW = 2 * K + 2;
  localparam int MU = int'(mu_calc(Q, K));

  logic advance;

  logic            v1_q, v1_d;
  logic [2*K-1:0]  x1_q, x1_d;
  logic [PW-1:0]   p1_q, p1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  logic            v2_q, v2_d;
  logic [K+1:0]    r2_q, r2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic            v3_q, v3_d;
  logic [K-1:0]    data3_q, data3_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;

  logic [K:0]      q1;
  logic [K:0]      q3;
  logic [PW-1:0]   r_full;
  logic [K-1:0]    corr_res;

  // Whole pipe moves in lockstep; only the output register can block it.
  assign advance  = !v3_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    q1      = (K+1)'(in_data >> (K - 1));
    v1_d    = in_valid;
    x1_d    = in_data;
    p1_d    = PW'(q1) * PW'(MU);
    tag1_d  = in_tag;

    q3      = (K+1)'(p1_q >> (K + 1));
    r_full  = PW'(x1_q) - PW'(q3) * PW'(Q);
    v2_d    = v1_q;
    r2_d    = (K+2)'(r_full);
    tag2_d  = tag1_q;

    v3_d    = v2_q;
    data3_d = corr_res;
    tag3_d  = tag2_q;
  end

  barrett_corr #(
    .WIDTH(K),
    .Q    (Q)
  ) u_corr (
    .r_i  (r2_q),
    .res_o(corr_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      x1_q    <= '0;
      p1_q    <= '0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      r2_q    <= '0;
      tag2_q  <= '0;
      v3_q    <= 1'b0;
      data3_q <= '0;
      tag3_q  <= '0;
    end else if (advance) begin
      v1_q    <= v1_d;
      x1_q    <= x1_d;
      p1_q    <= p1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      r2_q    <= r2_d;
      tag2_q  <= tag2_d;
      v3_q    <= v3_d;
      data3_q <= data3_d;
      tag3_q  <= tag3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_data  = data3_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Scoreboard bench for barrett_reduce_pipe: expected residues are queued on
// input accept and compared against each output transfer.
module tb_barrett_reduce_pipe;

  localparam int WIDTH = 8;
  localparam int Q     = 251;
  localparam int TAG_W = 4;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] in_data;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  bit verbose  = 1'b1;

  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] stall_data;
  logic [TAG_W-1:0] stall_tag;

  barrett_reduce_pipe #(
    .WIDTH(WIDTH),
    .Q    (Q),
    .TAG_W(TAG_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: samples at the falling edge, between the TB drive point and the
  // next rising edge, so the handshake seen here is the one that will fire.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_eq("stall_valid", 32'(out_valid), 32'd1);
          check_eq("stall_data", 32'(out_data), 32'(stall_data));
          check_eq("stall_tag", 32'(out_tag), 32'(stall_tag));
        end
        if (out_valid && out_ready) begin
          check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("out_data", 32'(out_data), 32'(e.res));
            check_eq("out_tag", 32'(out_tag), 32'(e.tag));
            if (verbose)
              $display("out tag=%0d data=%0d exp=%0d", out_tag, out_data, e.res);
          end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        stall_tag  = out_tag;
        if (in_valid && in_ready) begin
          e.res = WIDTH'(in_data % 16'(Q));
          e.tag = in_tag;
          sb.push_back(e);
          n_acc++;
        end
      end
    end
  end

  task automatic send(input logic [2*WIDTH-1:0] x, input logic [TAG_W-1:0] t);
    int   guard;
    logic acc;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = x;
    in_tag   = t;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check_eq("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 2000) begin
      @(posedge clk);
      #2;
      g++;
    end
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic measure_latency(input string tag);
    int lat;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #2;
      lat++;
    end
    check_eq(tag, 32'(lat), 32'd3);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_tag", 32'(out_tag), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #2;

    // Small product: no correction needed.
    send(16'd231, 4'd5);
    measure_latency("lat_231");
    drain("drain_231");

    // One correction: r = 259 before the final subtract.
    send(16'd23100, 4'd10);
    measure_latency("lat_23100");
    drain("drain_23100");

    // Back-to-back boundaries including all-ones input.
    send(16'd0, 4'd1);
    send(16'd251, 4'd2);
    send(16'd502, 4'd3);
    send(16'd65025, 4'd4);
    send(16'd65535, 4'd6);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("b2b_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #2;
    end
    drain("drain_b2b");

    // Stream with a 5-cycle output stall once the pipe is full.
    fork
      begin
        for (int i = 0; i < 10; i++) send(16'(1000 + i * 3001), 4'(i));
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        check_eq("full_out_valid", 32'(out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Reset with two operands in flight; nothing may emerge afterwards.
    send(16'd40000, 4'd7);
    send(16'd12345, 4'd8);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("midrst_quiet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;

    // Random traffic over the full input range.
    verbose = 1'b0;
    begin
      int cyc;
      int target;
      cyc    = 0;
      target = n_acc + 10000;
      while (n_acc < target && cyc < 60000) begin
        in_valid  = ($urandom_range(3) != 0);
        in_data   = 16'($urandom);
        in_tag    = 4'($urandom);
        out_ready = ($urandom_range(3) != 0);
        @(posedge clk);
        #2;
        cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_eq("rand_count", 32'(n_acc >= target), 32'd1);
    end
    drain("drain_rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
